// File: rtl/div_iter.sv
// Iterative restoring divider, RADIX_BITS quotient bits per cycle; stop rises WIDTH/RADIX_BITS+2 edges after accept (1 for div-by-zero/overflow).
// Start is a level held until stop; busy stalls the EX stage; cancel flushes back to IDLE without touching the outputs.
module div_iter #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start_i,
  input  logic             div_cancel_i,
  input  logic             div_op1_signed_i,
  input  logic             div_op2_signed_i,
  input  logic [WIDTH-1:0] div_op1_i,
  input  logic [WIDTH-1:0] div_op2_i,
  output logic             div_busy_o,
  output logic             div_stop_o,
  output logic [WIDTH-1:0] div_res_o,
  output logic [WIDTH-1:0] div_rem_o
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0]    L_LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] L_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic             r_s1;
  logic             r_s2;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_stop;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_remo;

  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic             w_div_zero;
  logic             w_ovf;
  logic [WIDTH:0]   w_part;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;

  assign w_neg1     = r_s1 & r_op1[WIDTH-1];
  assign w_neg2     = r_s2 & r_op2[WIDTH-1];
  assign w_abs1     = w_neg1 ? -r_op1 : r_op1;
  assign w_abs2     = w_neg2 ? -r_op2 : r_op2;
  assign w_div_zero = (r_op2 == '0);
  assign w_ovf      = r_s1 & r_s2 & (r_op1 == L_MIN) & (r_op2 == '1);

  // The dividend is shifted out of r_quo while quotient bits shift in behind it.
  always_comb begin
    w_rem  = r_rem;
    w_quo  = r_quo;
    w_part = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      w_part = {w_rem, w_quo[WIDTH-1]};
      w_quo  = {w_quo[WIDTH-2:0], 1'b0};
      if (w_part >= {1'b0, r_div}) begin
        w_part   = w_part - {1'b0, r_div};
        w_quo[0] = 1'b1;
      end
      w_rem = w_part[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op1   <= '0;
      r_op2   <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_stop  <= 1'b0;
      r_res   <= '0;
      r_remo  <= '0;
    end else if (div_cancel_i && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_start_i && !div_cancel_i) begin
            r_op1   <= div_op1_i;
            r_op2   <= div_op2_i;
            r_s1    <= div_op1_signed_i;
            r_s2    <= div_op2_signed_i;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          if (w_div_zero) begin
            r_res   <= '1;
            r_remo  <= r_op1;
            r_busy  <= 1'b0;
            r_stop  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_ovf) begin
            r_res   <= r_op1;
            r_remo  <= '0;
            r_busy  <= 1'b0;
            r_stop  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_rem   <= '0;
            r_quo   <= w_abs1;
            r_div   <= w_abs2;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_rem;
          r_quo <= w_quo;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == L_LAST) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_res   <= r_neg_q ? -r_quo : r_quo;
          r_remo  <= r_neg_r ? -r_rem : r_rem;
          r_busy  <= 1'b0;
          r_stop  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!div_start_i) begin
            r_stop  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_stop  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign div_busy_o = r_busy;
  assign div_stop_o = r_stop;
  assign div_res_o  = r_res;
  assign div_rem_o  = r_remo;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a 32-bit radix-2 instance and a 16-bit radix-16 instance.
module tb_div_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st32, cn32, as32, bs32;
  logic [31:0] a32, b32;
  logic        busy32, stop32;
  logic [31:0] res32, rem32;
  logic        st16, cn16, as16, bs16;
  logic [15:0] a16, b16;
  logic        busy16, stop16;
  logic [15:0] res16, rem16;

  int n_vec = 0;
  int n_err = 0;

  div_iter u_dut32 (
    .clk(clk), .rst(rst),
    .div_start_i(st32), .div_cancel_i(cn32),
    .div_op1_signed_i(as32), .div_op2_signed_i(bs32),
    .div_op1_i(a32), .div_op2_i(b32),
    .div_busy_o(busy32), .div_stop_o(stop32),
    .div_res_o(res32), .div_rem_o(rem32)
  );

  div_iter #(.WIDTH(16), .RADIX_BITS(4)) u_dut16 (
    .clk(clk), .rst(rst),
    .div_start_i(st16), .div_cancel_i(cn16),
    .div_op1_signed_i(as16), .div_op2_signed_i(bs16),
    .div_op1_i(a16), .div_op2_i(b16),
    .div_busy_o(busy16), .div_stop_o(stop16),
    .div_res_o(res16), .div_rem_o(rem16)
  );

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    bit          sa;
    bit          sb;
    logic [31:0] er;
    logic [31:0] em;
    int          lat;
  } vec_t;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drives one request and reports what was observed; callers do the comparisons.
  task automatic do_op(input bit use16, input logic [31:0] a, input logic [31:0] b,
                       input bit sa, input bit sb, input bit hold,
                       output int lat, output bit busy_ok,
                       output logic [31:0] r, output logic [31:0] m);
    busy_ok = 1'b1;
    lat     = -1;
    if (use16) begin
      st16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; as16 = sa; bs16 = sb;
    end else begin
      st32 = 1'b1; a32 = a; b32 = b; as32 = sa; bs32 = sb;
    end
    step;
    a32 = ~a; b32 = ~b; as32 = ~sa; bs32 = ~sb;
    a16 = ~a[15:0]; b16 = ~b[15:0]; as16 = ~sa; bs16 = ~sb;
    if (!(use16 ? busy16 : busy32)) busy_ok = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step;
      if (use16 ? stop16 : stop32) begin
        lat = k;
        if (use16 ? busy16 : busy32) busy_ok = 1'b0;
        break;
      end
      if (!(use16 ? busy16 : busy32)) busy_ok = 1'b0;
    end
    r = use16 ? {16'h0, res16} : res32;
    m = use16 ? {16'h0, rem16} : rem32;
    if (!hold) begin
      st32 = 1'b0; st16 = 1'b0;
      step;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    n_vec++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL rst_busy32: got %b want 0", busy32); end
    n_vec++; if (stop32 !== 1'b0) begin n_err++; $display("FAIL rst_stop32: got %b want 0", stop32); end
    n_vec++; if (res32 !== 32'h0) begin n_err++; $display("FAIL rst_res32: got %h want 0", res32); end
    n_vec++; if (rem32 !== 32'h0) begin n_err++; $display("FAIL rst_rem32: got %h want 0", rem32); end
    n_vec++; if ({busy16, stop16} !== 2'b00) begin n_err++; $display("FAIL rst_flags16: got %b want 00", {busy16, stop16}); end
    n_vec++; if ({res16, rem16} !== 32'h0) begin n_err++; $display("FAIL rst_out16: got %h want 0", {res16, rem16}); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_arith;
    vec_t        tbl[8];
    int          lat;
    bit          bok;
    logic [31:0] r, m;
    tbl[0] = '{"u_100_7",    32'd100,      32'd7,        1'b0, 1'b0, 32'd14,        32'd2,        34};
    tbl[1] = '{"s_m100_7",   32'hFFFFFF9C, 32'd7,        1'b1, 1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE, 34};
    tbl[2] = '{"u1_m100_7",  32'hFFFFFF9C, 32'd7,        1'b0, 1'b1, 32'd613566742, 32'd2,        34};
    tbl[3] = '{"s_100_m7",   32'd100,      32'hFFFFFFF9, 1'b1, 1'b1, 32'hFFFFFFF2,  32'd2,        34};
    tbl[4] = '{"dz_u",       32'h12345678, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFF,  32'h12345678, 1};
    tbl[5] = '{"dz_s_neg",   32'hFFFFFFF0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFF,  32'hFFFFFFF0, 1};
    tbl[6] = '{"ovf_s",      32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000000,  32'h0,        1};
    tbl[7] = '{"ovf_u",      32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,         32'h80000000, 34};
    foreach (tbl[i]) begin
      do_op(1'b0, tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb, 1'b0, lat, bok, r, m);
      n_vec++; if (lat != tbl[i].lat) begin n_err++; $display("FAIL %s_lat: got %0d want %0d", tbl[i].nm, lat, tbl[i].lat); end
      n_vec++; if (bok !== 1'b1) begin n_err++; $display("FAIL %s_busy: got busy window error want clean", tbl[i].nm); end
      n_vec++; if (r !== tbl[i].er) begin n_err++; $display("FAIL %s_res: got %h want %h", tbl[i].nm, r, tbl[i].er); end
      n_vec++; if (m !== tbl[i].em) begin n_err++; $display("FAIL %s_rem: got %h want %h", tbl[i].nm, m, tbl[i].em); end
    end
  endtask

  task automatic test_cancel;
    int          lat;
    bit          bok;
    bit          seen;
    logic [31:0] r, m;
    do_op(1'b0, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, lat, bok, r, m);
    n_vec++; if ({r, m} !== {32'd333, 32'd1}) begin n_err++; $display("FAIL cancel_pre: got %0d/%0d want 333/1", r, m); end
    st32 = 1'b1; a32 = 32'd50; b32 = 32'd5; as32 = 1'b0; bs32 = 1'b0;
    step;
    for (int k = 0; k < 10; k++) step;
    cn32 = 1'b1; st32 = 1'b0;
    step;
    n_vec++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL cancel_busy: got %b want 0", busy32); end
    cn32 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step;
      if (stop32 || busy32) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL cancel_stop: got activity after cancel want none"); end
    n_vec++; if (res32 !== 32'd333) begin n_err++; $display("FAIL cancel_res: got %0d want 333", res32); end
    n_vec++; if (rem32 !== 32'd1) begin n_err++; $display("FAIL cancel_rem: got %0d want 1", rem32); end
  endtask

  task automatic test_cancel_idle;
    st32 = 1'b1; cn32 = 1'b1; a32 = 32'd9; b32 = 32'd2;
    step;
    step;
    n_vec++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL cancel_idle_busy: got %b want 0", busy32); end
    st32 = 1'b0; cn32 = 1'b0;
    step;
    n_vec++; if ({busy32, stop32} !== 2'b00) begin n_err++; $display("FAIL cancel_idle_flags: got %b want 00", {busy32, stop32}); end
  endtask

  task automatic test_handshake;
    int          lat;
    bit          bok;
    logic [31:0] r, m;
    do_op(1'b0, 32'd20, 32'd3, 1'b0, 1'b0, 1'b0, lat, bok, r, m);
    n_vec++; if (lat != 34) begin n_err++; $display("FAIL hs_lat: got %0d want 34", lat); end
    n_vec++; if (r !== 32'd6) begin n_err++; $display("FAIL hs_res: got %0d want 6", r); end
    n_vec++; if (m !== 32'd2) begin n_err++; $display("FAIL hs_rem: got %0d want 2", m); end
  endtask

  task automatic test_reset_mid;
    st32 = 1'b1; a32 = 32'd1000; b32 = 32'd7; as32 = 1'b0; bs32 = 1'b0;
    step;
    for (int k = 0; k < 6; k++) step;
    rst = 1'b1; st32 = 1'b0;
    step;
    n_vec++; if ({busy32, stop32} !== 2'b00) begin n_err++; $display("FAIL rstmid_flags: got %b want 00", {busy32, stop32}); end
    n_vec++; if (res32 !== 32'h0) begin n_err++; $display("FAIL rstmid_res: got %h want 0", res32); end
    n_vec++; if (rem32 !== 32'h0) begin n_err++; $display("FAIL rstmid_rem: got %h want 0", rem32); end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) step;
    n_vec++; if ({busy32, stop32} !== 2'b00) begin n_err++; $display("FAIL rstmid_idle: got %b want 00", {busy32, stop32}); end
  endtask

  task automatic test_radix4;
    int          lat;
    bit          bok;
    bit          hold_ok;
    logic [31:0] r, m;
    do_op(1'b1, 32'hFFFF, 32'h0010, 1'b0, 1'b0, 1'b1, lat, bok, r, m);
    n_vec++; if (lat != 6) begin n_err++; $display("FAIL r4_lat: got %0d want 6", lat); end
    n_vec++; if (bok !== 1'b1) begin n_err++; $display("FAIL r4_busy: got busy window error want clean"); end
    n_vec++; if (r !== 32'h0FFF) begin n_err++; $display("FAIL r4_res: got %h want 0fff", r); end
    n_vec++; if (m !== 32'h000F) begin n_err++; $display("FAIL r4_rem: got %h want 000f", m); end
    hold_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step;
      if (!stop16 || busy16 || res16 !== 16'h0FFF) hold_ok = 1'b0;
    end
    n_vec++; if (hold_ok !== 1'b1) begin n_err++; $display("FAIL r4_hold: got stop/busy/res disturbed while start held want stable"); end
    st16 = 1'b0;
    step;
    n_vec++; if (stop16 !== 1'b0) begin n_err++; $display("FAIL r4_release: got stop %b want 0", stop16); end
    do_op(1'b1, 32'hFFF9, 32'h0002, 1'b1, 1'b1, 1'b0, lat, bok, r, m);
    n_vec++; if (lat != 6) begin n_err++; $display("FAIL r4s_lat: got %0d want 6", lat); end
    n_vec++; if (r !== 32'hFFFD) begin n_err++; $display("FAIL r4s_res: got %h want fffd", r); end
    n_vec++; if (m !== 32'hFFFF) begin n_err++; $display("FAIL r4s_rem: got %h want ffff", m); end
  endtask

  initial begin
    rst  = 1'b1;
    st32 = 1'b0; cn32 = 1'b0; as32 = 1'b0; bs32 = 1'b0; a32 = '0; b32 = '0;
    st16 = 1'b0; cn16 = 1'b0; as16 = 1'b0; bs16 = 1'b0; a16 = '0; b16 = '0;
    test_reset;
    test_arith;
    test_cancel;
    test_cancel_idle;
    test_handshake;
    test_reset_mid;
    test_radix4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative integer divider for the RISC-V M-extension execute stage. It is the successor to the fixed 32-bit `div` unit, with three additions: configurable operand width, a configurable number of quotient bits retired per cycle, and an explicit busy flag. Signed and unsigned mode is selected per operand, and RISC-V divide-by-zero and overflow results come from an early-out path. The EX stage drives it with a start/stop handshake and stalls the pipeline while it is busy.

## Interface
- `WIDTH`, default 32: operand and result width. Must be ≥4 and a multiple of `RADIX_BITS`.
- `RADIX_BITS`, default 1: quotient bits per cycle (1, 2 or 4). Implemented as unrolled restoring steps. N = WIDTH/RADIX_BITS iterations.
- `clk  input  1`: clock, rising edge.
- `rst  input  1`: synchronous, active-high reset.
- `div_start_i  input  1`: request; a level, held high until `div_stop_o` is seen.
- `div_cancel_i  input  1`: abort the current operation (pipeline flush).
- `div_op1_signed_i  input  1`: dividend is two's complement.
- `div_op2_signed_i  input  1`: divisor is two's complement.
- `div_op1_i  input  WIDTH`: dividend. Sampled only on the acceptance edge.
- `div_op2_i  input  WIDTH`: divisor. Sampled only on the acceptance edge.
- `div_busy_o  output  1`: high in PREP, CALC and FIX.
- `div_stop_o  output  1`: result valid; high only in DONE.
- `div_res_o  output  WIDTH`: quotient, registered.
- `div_rem_o  output  WIDTH`: remainder, registered.

## Operation
**States:** IDLE, PREP, CALC, FIX, DONE.

**Transitions:**
- **IDLE → PREP**: `div_start_i`=1 and `div_cancel_i`=0. This is the acceptance edge; operands and sign flags are latched.
- **PREP → special-case DONE**:
  - An operand is negative when its signed flag is 1 and its MSB is 1.
  - Divisor == 0: `res` = all ones, `rem` = op1 (raw bits). Go to DONE.
  - Both signed, op1 == 100…0 and op2 == all ones: `res` = op1, `rem` = 0. Go to DONE.
- **PREP → CALC (normal case)**: absolute values are loaded into the working registers, the iteration counter is cleared, and the state moves to CALC.
- **CALC**:
  - Each cycle performs RADIX_BITS shift/compare/subtract steps.
  - After N cycles, go to FIX.
- **FIX**:
  - Quotient is negated if exactly one operand is negative.
  - Remainder is negated if the dividend is negative.
  - Results are written to the outputs; go to DONE.
- **DONE**:
  - `div_stop_o`=1 and the outputs are stable.
  - Stay while `div_start_i`=1; go to IDLE on the first cycle `div_start_i`=0.
  - A new request therefore needs start low for ≥1 cycle.

**Cancel:**
- `div_cancel_i`=1 in any state other than IDLE → IDLE on the next edge.
- `div_stop_o` never asserts for the cancelled operation, and `div_res_o`/`div_rem_o` keep their previous values.
- In IDLE, cancel has priority over start; the request is not accepted.

**Arithmetic:**
- Internal partial remainder is WIDTH+1 bits.
- Negation is two's complement modulo 2^WIDTH.
- Quotient truncates toward zero.

## Timing
- Reset (synchronous):
  - State → IDLE.
  - `div_busy_o`=0, `div_stop_o`=0, `div_res_o`=0, `div_rem_o`=0.
  - Reset has priority over cancel and start, including in mid-operation.
- Normal latency: `div_stop_o` rises N+2 edges after the acceptance edge (1 PREP + N CALC + 1 FIX). WIDTH=32, RADIX_BITS=1 gives 34.
- Special-case latency: `div_stop_o` rises 1 edge after the acceptance edge.
- `div_busy_o` rises on the acceptance edge and falls on the edge entering DONE or IDLE.
- Outputs change only on the edge entering DONE. They hold through DONE and the following IDLE until the next completion or reset.
- Operand inputs may change freely after the acceptance edge without effect.

## Test plan
- **Unsigned divide, full latency:** op1=100, op2=7, both unsigned → `res`=14, `rem`=2, stop exactly 34 edges after acceptance, busy high for the 33 preceding cycles.
- **Signed vs unsigned interpretation of the same bits:**
  - op1=0xFFFFFF9C, op2=7, both signed → `res`=0xFFFFFFF2, `rem`=0xFFFFFFFE.
  - Same bits with op1 unsigned → `res`=613566742, `rem`=2.
- **Divide by zero:** op1=0x12345678, op2=0 → `res`=0xFFFFFFFF, `rem`=0x12345678, stop 1 edge after acceptance.
- **Signed overflow:**
  - 0x80000000 / 0xFFFFFFFF, both signed → `res`=0x80000000, `rem`=0 (early-out).
  - Same operands unsigned → `res`=0, `rem`=0x80000000 after 34 edges.
- **Cancel, reset and handshake recovery:**
  - Cancel on the 10th CALC cycle → busy falls next edge, stop never rises, outputs keep their prior values.
  - Start deasserted 1 cycle, then 20/3 → `res`=6, `rem`=2.
  - `rst` asserted mid-CALC → all outputs 0 and IDLE next edge.
- **Wider radix:** WIDTH=16, RADIX_BITS=4; 0xFFFF/0x0010 unsigned → `res`=0x0FFF, `rem`=0x000F, stop 6 edges after acceptance. Also check that holding start high in DONE keeps stop high and does not start a second operation.
